// File: rtl/des_pkg.sv
// Shared DES constants: FIPS 46-3 permutation tables, S-box contents, key
// rotation schedule, FSM state type and the helper functions built on them.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Table entries are 1-based DES bit numbers; DES bit 1 is the MSB of each vector.
  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int unsigned SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Row-major: index = {b1, b6, b2..b5} of the 6-bit S-box input.
  localparam logic [3:0] SBOX_T [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,   0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,   15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,   3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,   13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,   13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,   1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,   13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,   3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,   14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,   11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,   10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,   4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,   13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,   6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,   1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,   2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
  };

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int unsigned i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int unsigned i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic by2);
    return by2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic by2);
    return by2 ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_decrypt_core_if.sv
// Block transfer interface: ciphertext/key in, plaintext out, each side valid/ready.
interface des_decrypt_core_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ciphertext;
  logic [63:0] key;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] plaintext;
  logic        busy;

  modport slave (
    input  in_valid, ciphertext, key, mode, out_ready,
    output in_ready, out_valid, plaintext, busy
  );

  modport master (
    output in_valid, ciphertext, key, mode, out_ready,
    input  in_ready, out_valid, plaintext, busy
  );
endinterface

// File: rtl/des_f.sv
// DES round function f(R,K) = P(S(E(R) ^ K)); purely combinational.
module des_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] subkey,
  output logic [31:0] f_out
);
  logic [47:0] x;
  logic [31:0] s_out;

  assign x = e_expand(r) ^ subkey;

  SBox1 u_s1 (.din(x[47:42]), .dout(s_out[31:28]));
  SBox2 u_s2 (.din(x[41:36]), .dout(s_out[27:24]));
  SBox3 u_s3 (.din(x[35:30]), .dout(s_out[23:20]));
  SBox4 u_s4 (.din(x[29:24]), .dout(s_out[19:16]));
  SBox5 u_s5 (.din(x[23:18]), .dout(s_out[15:12]));
  SBox6 u_s6 (.din(x[17:12]), .dout(s_out[11:8]));
  SBox7 u_s7 (.din(x[11:6]),  .dout(s_out[7:4]));
  SBox8 u_s8 (.din(x[5:0]),   .dout(s_out[3:0]));

  assign f_out = p_perm(s_out);
endmodule

// File: rtl/des_sbox.sv
// DES substitution boxes S1..S8: 6-bit input, 4-bit output, contents from des_pkg.
module SBox1 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = SBOX_T[0][{din[5], din[0], din[4:1]}];
endmodule

module SBox2 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = SBOX_T[1][{din[5], din[0], din[4:1]}];
endmodule

module SBox3 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = SBOX_T[2][{din[5], din[0], din[4:1]}];
endmodule

module SBox4 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = SBOX_T[3][{din[5], din[0], din[4:1]}];
endmodule

module SBox5 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = SBOX_T[4][{din[5], din[0], din[4:1]}];
endmodule

module SBox6 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = SBOX_T[5][{din[5], din[0], din[4:1]}];
endmodule

module SBox7 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = SBOX_T[6][{din[5], din[0], din[4:1]}];
endmodule

module SBox8 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = SBOX_T[7][{din[5], din[0], din[4:1]}];
endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES core: one Feistel round per clock, subkeys derived on the fly
// from C/D (right rotations for decrypt, optional left rotations for encrypt).
module des_decrypt_core
  import des_pkg::*;
#(
  parameter int unsigned ENC_SUPPORT = 0,
  parameter int unsigned CLEAR_KEY   = 1
) (
  input logic              clk,
  input logic              rst_n,
  des_decrypt_core_if.slave bus
);
  state_t      state, state_nxt;
  logic [3:0]  rnd;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic        enc_q;
  logic [63:0] pt_q;

  logic        in_ready_c, out_valid_c, busy_c;
  logic        accept, last_round;
  logic [27:0] c_use, d_use, c_rot, d_rot;
  logic [47:0] subkey;
  logic [31:0] f_out, r_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = ROUND;
      end
      ROUND: begin
        busy_c = 1'b1;
        if (rnd == 4'd15) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept     = (state == IDLE) && bus.in_valid;
  assign last_round = (state == ROUND) && (rnd == 4'd15);

  // Encrypt rotates before use (subkey sees the rotated value); decrypt uses
  // C/D as-is and rotates right afterwards, walking the schedule backwards.
  always_comb begin
    if (enc_q) begin
      c_use = rotl28(c_q, SHIFT_T[rnd] == 32'd2);
      d_use = rotl28(d_q, SHIFT_T[rnd] == 32'd2);
      c_rot = c_use;
      d_rot = d_use;
    end else begin
      c_use = c_q;
      d_use = d_q;
      c_rot = rotr28(c_q, SHIFT_T[~rnd] == 32'd2);
      d_rot = rotr28(d_q, SHIFT_T[~rnd] == 32'd2);
    end
  end

  assign subkey = pc2_perm({c_use, d_use});

  des_f u_f (
    .r      (r_q),
    .subkey (subkey),
    .f_out  (f_out)
  );

  assign r_new = l_q ^ f_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q   <= '0;
      r_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      rnd   <= '0;
      enc_q <= 1'b0;
      pt_q  <= '0;
    end else if (accept) begin
      {l_q, r_q} <= ip_perm(bus.ciphertext);
      {c_q, d_q} <= pc1_perm(bus.key);
      rnd        <= '0;
      enc_q      <= (ENC_SUPPORT != 0) && bus.mode;
    end else if (state == ROUND) begin
      l_q <= r_q;
      r_q <= r_new;
      rnd <= rnd + 4'd1;
      if (last_round && (CLEAR_KEY != 0)) begin
        c_q <= '0;
        d_q <= '0;
      end else begin
        c_q <= c_rot;
        d_q <= d_rot;
      end
      // Result is taken from the round-16 next values, with the final L/R swap.
      if (last_round) pt_q <= fp_perm({r_new, r_q});
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.plaintext = pt_q;

`ifndef SYNTHESIS
  logic [55:0] cd_init;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cd_init <= '0;
    else if (accept) cd_init <= pc1_perm(bus.key);
  end

  // Decrypt rotations total 28 per half, so C/D must land back on PC1(key).
  always_ff @(posedge clk) begin
    if (rst_n && last_round && !enc_q)
      assert ({c_rot, d_rot} == cd_init)
        else $error("key schedule did not return to its PC1 value");
  end
`endif
endmodule
